// File: rtl/dac_spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dac_spi_pkg : shared types and frame layout for the DAC SPI transmit  |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package dac_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LDAC  = 3'd4
    } state_t;

    localparam int FRAME_W      = 16;
    localparam int DATA_W       = 10;
    localparam int BIT_CNT_W    = 5;
    localparam int POS_BUF      = 14;
    localparam int POS_GA_N     = 13;
    localparam int POS_SHDN_N   = 12;
    localparam int POS_DATA_LSB = 2;
    localparam logic [POS_DATA_LSB-1:0] FRAME_PAD = 2'b00;

    // MCP4911 write command: bit 15 selects the DAC register and is always 0.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              cfg_buf,
        input logic              cfg_ga_n,
        input logic              cfg_shdn_n,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f                            = '0;
        f[POS_BUF]                   = cfg_buf;
        f[POS_GA_N]                  = cfg_ga_n;
        f[POS_SHDN_N]                = cfg_shdn_n;
        f[POS_DATA_LSB +: DATA_W]    = data;
        f[POS_DATA_LSB-1:0]          = FRAME_PAD;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dac_spi_tx_if : sample input and DAC pin bundle for dac_spi_tx        |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
interface dac_spi_tx_if;
    import dac_spi_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              dac_sck;
    logic              dac_cs_n;
    logic              dac_sdi;
    logic              dac_ld_n;
    logic              busy;
    logic              overrun;

    modport master (
        input  data_in, load,
        output dac_sck, dac_cs_n, dac_sdi, dac_ld_n, busy, overrun
    );

    modport slave (
        output data_in, load,
        input  dac_sck, dac_cs_n, dac_sdi, dac_ld_n, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sck_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sck_tick_gen : one-cycle tick every CLK_DIV sysclk cycles while en    |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module sck_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int                c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_div_cnt;

    // Held at zero while disabled so every frame starts on a full tick.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (!en || (r_div_cnt == c_last)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_cnt_w'(1);
        end
    end

    assign tick = en && (r_div_cnt == c_last);
endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dac_spi_tx : serialises 10-bit samples to an MCP4911-class SPI DAC    |
// | Option     : DAC_SPI_SKID_EN adds a one-entry sample holding register |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int   CLK_DIV    = 25,
    parameter logic CFG_BUF    = 1'b0,
    parameter logic CFG_GA_N   = 1'b1,
    parameter logic CFG_SHDN_N = 1'b1
) (
    input  logic         sysclk,
    input  logic         rst_n,
    dac_spi_tx_if.master bus
);
    localparam logic [BIT_CNT_W-1:0] c_last_bit = BIT_CNT_W'(FRAME_W);

    state_t               r_state, w_state_nxt;
    logic [FRAME_W-1:0]   r_shift, w_shift_nxt;
    logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic                 r_sck, w_sck_nxt;
    logic                 r_cs_n, w_cs_n_nxt;
    logic                 r_ld_n, w_ld_n_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_overrun, w_overrun_nxt;
    logic                 w_tick, w_tick_en, w_start;
    logic [FRAME_W-1:0]   w_new_frame, w_start_frame;

`ifdef DAC_SPI_SKID_EN
    logic                 r_hold_vld, w_hold_vld_nxt;
    logic [FRAME_W-1:0]   r_hold_frame, w_hold_frame_nxt;
`else
`endif

    assign w_new_frame = build_frame(CFG_BUF, CFG_GA_N, CFG_SHDN_N, bus.data_in);
    assign w_tick_en   = (r_state != ST_IDLE);

    sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .en     (w_tick_en),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_sck_nxt     = r_sck;
        w_cs_n_nxt    = r_cs_n;
        w_ld_n_nxt    = r_ld_n;
        w_busy_nxt    = r_busy;
        w_overrun_nxt = r_overrun;
        w_start       = 1'b0;
        w_start_frame = w_new_frame;
`ifdef DAC_SPI_SKID_EN
        w_hold_vld_nxt   = r_hold_vld;
        w_hold_frame_nxt = r_hold_frame;
        // Busy includes the last LDAC cycle; the newest sample always wins.
        if (r_busy && bus.load) begin
            if (r_hold_vld) begin
                w_overrun_nxt = 1'b1;
            end
            w_hold_vld_nxt   = 1'b1;
            w_hold_frame_nxt = w_new_frame;
        end
`else
        if (r_busy && bus.load) begin
            w_overrun_nxt = 1'b1;
        end
`endif

        case (r_state)
            ST_IDLE: begin
                if (bus.load) begin
                    w_start = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_state_nxt = ST_SHIFT;
                    w_sck_nxt   = 1'b1;
                end
            end
            ST_SHIFT: begin
                // The extra low half-period after the last fall gives CS_n hold time.
                if (w_tick) begin
                    if (r_sck) begin
                        w_sck_nxt     = 1'b0;
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        w_shift_nxt   = {r_shift[FRAME_W-2:0], 1'b0};
                    end else if (r_bit_cnt == c_last_bit) begin
                        w_state_nxt = ST_HOLD;
                        w_cs_n_nxt  = 1'b1;
                    end else begin
                        w_sck_nxt = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_state_nxt = ST_LDAC;
                    w_ld_n_nxt  = 1'b0;
                end
            end
            ST_LDAC: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_ld_n_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
`ifdef DAC_SPI_SKID_EN
                    if (r_hold_vld || bus.load) begin
                        w_start        = 1'b1;
                        w_start_frame  = bus.load ? w_new_frame : r_hold_frame;
                        w_hold_vld_nxt = 1'b0;
                    end
`else
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_start) begin
            w_state_nxt   = ST_SETUP;
            w_shift_nxt   = w_start_frame;
            w_bit_cnt_nxt = '0;
            w_sck_nxt     = 1'b0;
            w_cs_n_nxt    = 1'b0;
            w_ld_n_nxt    = 1'b1;
            w_busy_nxt    = 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sck     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_ld_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_sck     <= w_sck_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_ld_n    <= w_ld_n_nxt;
            r_busy    <= w_busy_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

`ifdef DAC_SPI_SKID_EN
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_hold_vld   <= 1'b0;
            r_hold_frame <= '0;
        end else begin
            r_hold_vld   <= w_hold_vld_nxt;
            r_hold_frame <= w_hold_frame_nxt;
        end
    end
`else
`endif

    assign bus.dac_sck  = r_sck;
    assign bus.dac_cs_n = r_cs_n;
    assign bus.dac_sdi  = r_shift[FRAME_W-1];
    assign bus.dac_ld_n = r_ld_n;
    assign bus.busy     = r_busy;
    assign bus.overrun  = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dac_spi_tx : bench for dac_spi_tx at CLK_DIV=4 and CLK_DIV=2       |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_dac_spi_tx;
    localparam int         NDUT     = 2;
    localparam int         DIV0     = 4;
    localparam int         DIV1     = 2;
    // {sck, cs_n, sdi, ld_n, busy, overrun}
    localparam logic [5:0] IDLE_OUT = 6'b010100;

    typedef struct packed {
        logic        act;
        logic [31:0] t;
        logic [15:0] frame;
        logic        ovr;
        logic        hv;
        logic [15:0] hf;
    } mstate_t;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       ld  [NDUT];
    logic [9:0] din [NDUT];
    logic [5:0] obs [NDUT];

    always #5 sysclk = ~sysclk;

    dac_spi_tx_if bus0 ();
    dac_spi_tx_if bus1 ();

    assign bus0.load    = ld[0];
    assign bus0.data_in = din[0];
    assign bus1.load    = ld[1];
    assign bus1.data_in = din[1];
    assign obs[0] = {bus0.dac_sck, bus0.dac_cs_n, bus0.dac_sdi, bus0.dac_ld_n, bus0.busy, bus0.overrun};
    assign obs[1] = {bus1.dac_sck, bus1.dac_cs_n, bus1.dac_sdi, bus1.dac_ld_n, bus1.busy, bus1.overrun};

    dac_spi_tx #(.CLK_DIV(DIV0)) u_dut0 (.sysclk(sysclk), .rst_n(rst_n), .bus(bus0.master));
    dac_spi_tx #(.CLK_DIV(DIV1)) u_dut1 (.sysclk(sysclk), .rst_n(rst_n), .bus(bus1.master));

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        chk_en;
    mstate_t     ms        [NDUT];
    logic [5:0]  prev      [NDUT];
    logic [15:0] sh        [NDUT];
    int          nb        [NDUT];
    int          run_cs    [NDUT];
    int          run_ld    [NDUT];
    int          run_busy  [NDUT];
    int          cs_len    [NDUT];
    int          ld_len    [NDUT];
    int          busy_len  [NDUT];
    int          ld_pulses [NDUT];
    int          last_fall [NDUT];
    int          cs_period [NDUT];
    int          wcnt      [NDUT];
    logic [15:0] wlog      [NDUT][32];
    int          wc;
    int          pulses;

    function automatic int dv(input int i);
        return (i == 0) ? DIV0 : DIV1;
    endfunction

    // Frame word with the default configuration: 0, BUF=0, GA_n=1, SHDN_n=1.
    function automatic logic [15:0] word_of(input logic [9:0] d);
        return {1'b0, 1'b0, 1'b1, 1'b1, d, 2'b00};
    endfunction

    // Reference behaviour: a frame is 35 ticks long from the accepting edge.
    function automatic mstate_t model_step(input mstate_t s, input logic rn, input logic l,
                                           input logic [9:0] d, input int div);
        mstate_t n;
        n = s;
        if (!rn) begin
            n.act = 1'b0; n.t = '0; n.ovr = 1'b0; n.hv = 1'b0;
        end else if (!s.act) begin
            if (l) begin
                n.act = 1'b1; n.t = '0; n.frame = word_of(d);
            end
        end else begin
`ifdef DAC_SPI_SKID_EN
            if (l) begin
                if (s.hv) n.ovr = 1'b1;
                n.hv = 1'b1;
                n.hf = word_of(d);
            end
`else
            if (l) n.ovr = 1'b1;
`endif
            if (s.t == 32'(35 * div - 1)) begin
                n.act = 1'b0;
`ifdef DAC_SPI_SKID_EN
                if (n.hv) begin
                    n.act = 1'b1; n.t = '0; n.frame = n.hf; n.hv = 1'b0;
                end
`endif
            end else begin
                n.t = s.t + 32'd1;
            end
        end
        return n;
    endfunction

    // Tick k of the frame: 0 setup, 1..32 shifting, 33 hold, 34 latch.
    function automatic logic [5:0] model_out(input mstate_t s, input int div);
        int   k, falls;
        logic sck, cs_n, sdi, ld_n;
        if (!s.act) return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, s.ovr};
        k     = int'(s.t) / div;
        falls = k / 2;
        sck   = (k >= 1) && (k <= 31) && (k % 2 == 1);
        cs_n  = (k >= 33);
        sdi   = (falls < 16) ? s.frame[15 - falls] : 1'b0;
        ld_n  = (k != 34);
        return {sck, cs_n, sdi, ld_n, 1'b1, s.ovr};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        logic [5:0] e, m, o;
        @(posedge sysclk);
        for (int i = 0; i < NDUT; i++) ms[i] = model_step(ms[i], rst_n, ld[i], din[i], dv(i));
        @(negedge sysclk);
        cyc++;
        for (int i = 0; i < NDUT; i++) begin
            o = obs[i];
            if (chk_en) begin
                e = model_out(ms[i], dv(i));
                m = e[4] ? 6'b110111 : 6'b111111;
                check($sformatf("dut%0d cycle %0d outputs", i, cyc), 32'(o & m), 32'(e & m));
            end
            if (o[5] && !prev[i][5] && !o[4]) begin
                sh[i] = {sh[i][14:0], o[3]};
                nb[i]++;
            end
            if (!o[4]) run_cs[i]++;
            if (!o[2]) run_ld[i]++;
            if (o[1])  run_busy[i]++;
            if (!o[4] && prev[i][4]) begin
                nb[i] = 0;
                if (last_fall[i] >= 0) cs_period[i] = cyc - last_fall[i];
                last_fall[i] = cyc;
            end
            if (o[4] && !prev[i][4]) begin
                cs_len[i] = run_cs[i]; run_cs[i] = 0;
                if (nb[i] == 16 && wcnt[i] < 32) begin
                    wlog[i][wcnt[i]] = sh[i];
                    wcnt[i]++;
                end
            end
            if (!o[2] && prev[i][2]) ld_pulses[i]++;
            if (o[2] && !prev[i][2]) begin ld_len[i] = run_ld[i]; run_ld[i] = 0; end
            if (!o[1] && prev[i][1]) begin busy_len[i] = run_busy[i]; run_busy[i] = 0; end
            prev[i] = o;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_load(input int i, input logic [9:0] d);
        ld[i]  = 1'b1;
        din[i] = d;
        step();
        ld[i]  = 1'b0;
        din[i] = ~d;
    endtask

    function automatic logic [15:0] last_word(input int i);
        return (wcnt[i] > 0) ? wlog[i][wcnt[i] - 1] : 16'hxxxx;
    endfunction

    initial begin
        rst_n  = 1'b0;
        chk_en = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            ld[i] = 1'b0; din[i] = '0; prev[i] = IDLE_OUT; sh[i] = '0; nb[i] = 0;
            run_cs[i] = 0; run_ld[i] = 0; run_busy[i] = 0; cs_len[i] = 0; ld_len[i] = 0;
            busy_len[i] = 0; ld_pulses[i] = 0; last_fall[i] = -1; cs_period[i] = 0; wcnt[i] = 0;
        end
        steps(3);
        check("reset state dut0", 32'(obs[0]), 32'(IDLE_OUT));
        check("reset state dut1", 32'(obs[1]), 32'(IDLE_OUT));
        rst_n  = 1'b1;
        chk_en = 1'b1;
        steps(2);

        // Basic frame at CLK_DIV=4
        pulse_load(0, 10'h2A5);
        steps(150);
        check("word 2A5", 32'(last_word(0)), 32'h3A94);
        check("cs_n low cycles", 32'(cs_len[0]), 32'd132);
        check("ld_n low cycles", 32'(ld_len[0]), 32'd4);
        check("busy high cycles", 32'(busy_len[0]), 32'd140);
        check("ldac pulse count", 32'(ld_pulses[0]), 32'd1);

        // Extreme codes, separate frames
        pulse_load(0, 10'h000);
        steps(150);
        check("word 000", 32'(last_word(0)), 32'h3000);
        check("sck idle low", 32'(obs[0][5]), 32'd0);
        pulse_load(0, 10'h3FF);
        steps(150);
        check("word 3FF", 32'(last_word(0)), 32'h3FFC);
        check("word count 3", 32'(wcnt[0]), 32'd3);

        // Second load 20 cycles into a frame
        pulse_load(0, 10'h155);
        steps(19);
        pulse_load(0, 10'h0AA);
        steps(150);
`ifdef DAC_SPI_SKID_EN
        check("busy load word count", 32'(wcnt[0]), 32'd5);
        check("held word sent", 32'(last_word(0)), 32'h32A8);
        check("overrun after one held", 32'(obs[0][0]), 32'd0);
`else
        check("busy load word count", 32'(wcnt[0]), 32'd4);
        check("first word kept", 32'(last_word(0)), 32'h3554);
        check("overrun set", 32'(obs[0][0]), 32'd1);
`endif
        pulse_load(0, 10'h001);
        steps(150);
        check("clean frame word", 32'(last_word(0)), 32'h3004);
`ifdef DAC_SPI_SKID_EN
        check("overrun stays clear", 32'(obs[0][0]), 32'd0);
`else
        check("overrun sticky", 32'(obs[0][0]), 32'd1);
`endif

        // Reset in the middle of SHIFT
        pulse_load(0, 10'h123);
        steps(50);
        wc     = wcnt[0];
        pulses = ld_pulses[0];
        rst_n  = 1'b0;
        step();
        rst_n  = 1'b1;
        check("abort outputs", 32'(obs[0]), 32'(IDLE_OUT));
        steps(150);
        check("abort no ldac", 32'(ld_pulses[0]), 32'(pulses));
        check("abort no word", 32'(wcnt[0]), 32'(wc));
        pulse_load(0, 10'h2A5);
        steps(150);
        check("post-abort word", 32'(last_word(0)), 32'h3A94);
        check("post-abort cs_n low", 32'(cs_len[0]), 32'd132);

        // Three loads inside one frame
        wc = wcnt[0];
        pulse_load(0, 10'h100);
        steps(9);
        pulse_load(0, 10'h200);
        steps(9);
        pulse_load(0, 10'h300);
        steps(300);
`ifdef DAC_SPI_SKID_EN
        check("skid word count", 32'(wcnt[0]), 32'(wc + 2));
        check("skid first word", 32'(wlog[0][wc]), 32'h3400);
        check("skid second word", 32'(wlog[0][wc + 1]), 32'h3C00);
        check("skid busy back-to-back", 32'(busy_len[0]), 32'd280);
`else
        check("drop word count", 32'(wcnt[0]), 32'(wc + 1));
        check("drop first word", 32'(last_word(0)), 32'h3400);
        check("drop busy cycles", 32'(busy_len[0]), 32'd140);
`endif
        check("three loads overrun", 32'(obs[0][0]), 32'd1);

        // CLK_DIV=2 with load held high
        ld[1]  = 1'b1;
        din[1] = 10'h1C3;
        steps(400);
        ld[1]  = 1'b0;
        steps(200);
`ifdef DAC_SPI_SKID_EN
        check("div2 frame period", 32'(cs_period[1]), 32'd70);
`else
        check("div2 frame period", 32'(cs_period[1]), 32'd71);
        check("div2 busy cycles", 32'(busy_len[1]), 32'd70);
`endif
        check("div2 word", 32'(last_word(1)), 32'h370C);
        check("div2 many frames", 32'(wcnt[1] >= 5), 32'd1);
        check("div2 overrun", 32'(obs[1][0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
